weight_fifo_sched: RTL and testbench
====================================

# weight_fifo_sched

Scheduler for the weight FIFO. It accepts tile-fetch commands, streams weight rows from weight memory into the FIFO under credit-based flow control, and drains whole 32-row tiles from the FIFO head into the systolic array on request. It sits between the top-level TPU controller, the weight memory read port and the weight FIFO, and owns the only authoritative occupancy count of that FIFO.

## Interface
- TILE_ROWS, 32, rows per weight tile (one row = 32 weights of W_WIDTH+1 bits, from tpu_package)
- NUM_TILES, 4, FIFO capacity in tiles; DEPTH = TILE_ROWS*NUM_TILES = 128 rows
- ADDR_W, 16, weight memory row-address width
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  fetch command valid
- cmd_base_addr_i  in  ADDR_W  first row address of the command
- cmd_num_tiles_i  in  8  tiles to fetch (0 is legal)
- cmd_ready_o  out  1  fetch engine idle, command can be accepted
- fetch_done_o  out  1  one-cycle pulse: all rows of the command written into the FIFO
- mem_rd_en_o  out  1  weight memory row read strobe (registered)
- mem_addr_o  out  ADDR_W  row address for mem_rd_en_o (registered)
- mem_rd_valid_i  in  1  memory returns one row this cycle (data goes straight to the FIFO)
- fifo_write_en_o  out  1  FIFO write-enable level, high in FETCH and DRAIN
- fifo_sending_data_o  out  1  = mem_rd_valid_i while fetch state is not IDLE, else 0 (combinational)
- fifo_read_en_o  out  1  FIFO head read/advance strobe (registered)
- load_req_i  in  1  array requests the next tile (level, sampled in L_IDLE)
- array_shift_o  out  1  FIFO data_o is valid for the array this cycle
- tile_done_o  out  1  one-cycle pulse with the last array_shift_o of a tile
- weights_avail_o  out  1  occupancy >= TILE_ROWS
- occupancy_o  out  8  rows currently held in the FIFO (0..128)
- stall_cycles_o  out  32  performance counter (see Configuration)
- tiles_loaded_o  out  16  performance counter (see Configuration)

## Operation
- Fetch FSM: IDLE -> FETCH -> DRAIN -> IDLE.
  - IDLE: cmd_ready_o = 1. On cmd_valid_i & cmd_ready_o, latch the base address and set rows_left = cmd_num_tiles_i*TILE_ROWS (13 bits). Go to FETCH, or straight to DRAIN if rows_left = 0.
  - FETCH: issue one read per cycle when credit_ok = (occupancy + inflight < DEPTH) and rows_left > 0.
    - mem_addr_o = base + issued_count, wrapping modulo 2^ADDR_W.
    - On the last issue, go to DRAIN.
  - DRAIN: wait for inflight = 0, then pulse fetch_done_o and go to IDLE.
- inflight counter (0..DEPTH): +1 on issue, -1 on mem_rd_valid_i. Both in the same cycle leaves it unchanged.
- occupancy counter (0..DEPTH): +1 on a counted mem_rd_valid_i, -1 on fifo_read_en_o. Simultaneous events leave it unchanged.
  - mem_rd_valid_i in IDLE is ignored: not counted and not forwarded.
- Credit rule guarantees occupancy + inflight <= DEPTH, so the FIFO never sees a write when full. Any attempt to exceed DEPTH is a design error; a bench assertion must flag it.
- Load FSM: L_IDLE -> L_LOAD -> L_IDLE, independent of the fetch FSM and concurrent with it.
  - L_IDLE: if load_req_i & weights_avail_o, enter L_LOAD.
  - L_LOAD: fifo_read_en_o high for exactly TILE_ROWS consecutive cycles, then return to L_IDLE.
  - A new tile may start the cycle after return if load_req_i is still high and weights_avail_o is set.
- Because a tile starts only with occupancy >= TILE_ROWS, the load never underflows mid-tile.

## Timing
- Reset values: cmd_ready_o = 1 (IDLE) from the first cycle after reset; all other outputs and all counters are 0; both FSMs are in idle.
- Reset mid-operation aborts both FSMs and clears all counters. The memory and FIFO share rst_i, so no stale returns arrive after reset.
- Command accepted at edge N: first mem_rd_en_o at N+1; back-to-back issue at one row per cycle while credit allows.
- Load granted at edge N: fifo_read_en_o high N+1..N+32.
  - array_shift_o high N+2..N+33, one cycle later, matching the registered FIFO head.
  - tile_done_o pulses at N+33.
- occupancy_o and weights_avail_o are registered and reflect the previous edge's events.

## Configuration
- WFIFO_SCHED_PERF_EN defined:
  - stall_cycles_o counts cycles in FETCH with rows_left > 0 and credit_ok = 0.
  - tiles_loaded_o counts tile_done_o pulses.
  - Both saturate at all-ones and clear on rst_i.
- WFIFO_SCHED_PERF_EN undefined: both ports are present and tied to 0, with no counter logic.

## Test plan
- Reset, then cmd (base 0x0010, 1 tile), memory latency 2 -> mem_addr_o 0x0010..0x002F on 32 consecutive cycles; fetch_done_o 3 cycles after the last issue; occupancy_o = 32; weights_avail_o = 1.
- Cmd of 5 tiles with no loads -> issue stops at occupancy + inflight = 128. A later load of one tile frees 32 credits; all 160 rows eventually arrive and fetch_done_o pulses. With WFIFO_SCHED_PERF_EN, stall_cycles_o > 0.
- Load requested with occupancy 31 -> no fifo_read_en_o until the 32nd row lands. Then 32 read cycles, tile_done_o at grant+33, occupancy_o = 0.
- Concurrent fetch and load, with a row return and a read in the same cycle -> occupancy_o unchanged in that cycle; the inflight/occupancy invariant assertion holds throughout.
- cmd_num_tiles_i = 0 -> no mem_rd_en_o; fetch_done_o pulses 2 cycles after accept. Base 0xFFF0, 1 tile -> address wraps 0xFFFF -> 0x0000.
- rst_i asserted mid-tile-load and mid-fetch -> next cycle all outputs at reset values, cmd_ready_o = 1; a fresh command behaves as in the first scenario.

Source files
------------

// File: rtl/weight_fifo_sched.sv
// rtl/weight_fifo_sched.sv - weight FIFO fetch/load scheduler with credit flow control (option: WFIFO_SCHED_PERF_EN)
module weight_fifo_sched #(
    parameter int TILE_ROWS = 32,
    parameter int NUM_TILES = 4,
    parameter int ADDR_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    input  logic [ADDR_W-1:0] cmd_base_addr_i,
    input  logic [7:0]        cmd_num_tiles_i,
    output logic              cmd_ready_o,
    output logic              fetch_done_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rd_valid_i,
    output logic              fifo_write_en_o,
    output logic              fifo_sending_data_o,
    output logic              fifo_read_en_o,
    input  logic              load_req_i,
    output logic              array_shift_o,
    output logic              tile_done_o,
    output logic              weights_avail_o,
    output logic [7:0]        occupancy_o,
    output logic [31:0]       stall_cycles_o,
    output logic [15:0]       tiles_loaded_o
);
    localparam int DEPTH  = TILE_ROWS * NUM_TILES;
    localparam int LCNT_W = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

    typedef enum logic [1:0] {F_IDLE, F_FETCH, F_DRAIN} fstate_t;
    typedef enum logic {L_IDLE, L_LOAD} lstate_t;

    fstate_t             r_fstate, w_fstate_nxt;
    lstate_t             r_lstate, w_lstate_nxt;
    logic [12:0]         r_rows_left, w_rows_left_nxt;
    logic [12:0]         r_issued, w_issued_nxt;
    logic [ADDR_W-1:0]   r_base, w_base_nxt;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic [12:0]         w_cmd_rows;
    logic                w_issue;
    logic                w_fetch_done_nxt;
    logic [7:0]          r_inflight;
    logic [7:0]          r_occ, w_occ_nxt;
    logic                r_avail;
    logic                w_credit_ok;
    logic                w_rd_counted;
    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_fetch_done;
    logic [LCNT_W-1:0]   r_lcnt, w_lcnt_nxt;
    logic                w_tile_done_nxt;
    logic                r_shift;
    logic                r_tile_done;

    assign w_cmd_rows   = 13'(cmd_num_tiles_i) * 13'(TILE_ROWS);
    assign w_credit_ok  = ({1'b0, r_occ} + {1'b0, r_inflight}) < 9'(DEPTH);
    // Returns while idle are stray and never reach the FIFO count
    assign w_rd_counted = mem_rd_valid_i && (r_fstate != F_IDLE);
    assign w_occ_nxt    = r_occ + 8'(w_rd_counted) - 8'(fifo_read_en_o);

    // Fetch FSM next state; the accept cycle already issues the first row
    always_comb begin
        w_fstate_nxt     = r_fstate;
        w_rows_left_nxt  = r_rows_left;
        w_issued_nxt     = r_issued;
        w_base_nxt       = r_base;
        w_issue          = 1'b0;
        w_issue_addr     = r_base + ADDR_W'(r_issued);
        w_fetch_done_nxt = 1'b0;
        case (r_fstate)
            F_IDLE: begin
                if (cmd_valid_i) begin
                    w_base_nxt      = cmd_base_addr_i;
                    w_issued_nxt    = 13'd0;
                    w_rows_left_nxt = w_cmd_rows;
                    if (w_cmd_rows == 13'd0) begin
                        w_fstate_nxt = F_DRAIN;
                    end else begin
                        w_fstate_nxt = F_FETCH;
                        if (w_credit_ok) begin
                            w_issue         = 1'b1;
                            w_issue_addr    = cmd_base_addr_i;
                            w_issued_nxt    = 13'd1;
                            w_rows_left_nxt = w_cmd_rows - 13'd1;
                            if (w_cmd_rows == 13'd1) w_fstate_nxt = F_DRAIN;
                        end
                    end
                end
            end
            F_FETCH: begin
                if (w_credit_ok && (r_rows_left != 13'd0)) begin
                    w_issue         = 1'b1;
                    w_issued_nxt    = r_issued + 13'd1;
                    w_rows_left_nxt = r_rows_left - 13'd1;
                    if (r_rows_left == 13'd1) w_fstate_nxt = F_DRAIN;
                end
            end
            F_DRAIN: begin
                // Finish on the edge that retires the last outstanding row
                if ((r_inflight == 8'd0) || ((r_inflight == 8'd1) && w_rd_counted)) begin
                    w_fetch_done_nxt = 1'b1;
                    w_fstate_nxt     = F_IDLE;
                end
            end
            default: w_fstate_nxt = F_IDLE;
        endcase
    end

    // Fetch state, memory strobe and inflight/occupancy counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fstate     <= F_IDLE;
            r_rows_left  <= '0;
            r_issued     <= '0;
            r_base       <= '0;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_fetch_done <= 1'b0;
            r_inflight   <= '0;
            r_occ        <= '0;
            r_avail      <= 1'b0;
        end else begin
            r_fstate     <= w_fstate_nxt;
            r_rows_left  <= w_rows_left_nxt;
            r_issued     <= w_issued_nxt;
            r_base       <= w_base_nxt;
            r_mem_rd_en  <= w_issue;
            if (w_issue) r_mem_addr <= w_issue_addr;
            r_fetch_done <= w_fetch_done_nxt;
            r_inflight   <= r_inflight + 8'(w_issue) - 8'(w_rd_counted);
            r_occ        <= w_occ_nxt;
            r_avail      <= w_occ_nxt >= 8'(TILE_ROWS);
        end
    end

    // Load FSM next state: one whole tile per grant
    always_comb begin
        w_lstate_nxt    = r_lstate;
        w_lcnt_nxt      = r_lcnt;
        w_tile_done_nxt = 1'b0;
        case (r_lstate)
            L_IDLE: begin
                if (load_req_i && r_avail) begin
                    w_lstate_nxt = L_LOAD;
                    w_lcnt_nxt   = '0;
                end
            end
            L_LOAD: begin
                if (r_lcnt == LCNT_W'(TILE_ROWS - 1)) begin
                    w_lstate_nxt    = L_IDLE;
                    w_tile_done_nxt = 1'b1;
                end else begin
                    w_lcnt_nxt = r_lcnt + 1'b1;
                end
            end
            default: w_lstate_nxt = L_IDLE;
        endcase
    end

    // Load state plus the one-cycle-late array view of the FIFO head
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lstate    <= L_IDLE;
            r_lcnt      <= '0;
            r_shift     <= 1'b0;
            r_tile_done <= 1'b0;
        end else begin
            r_lstate    <= w_lstate_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_shift     <= fifo_read_en_o;
            r_tile_done <= w_tile_done_nxt;
        end
    end

`ifdef WFIFO_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_tile_cnt;

    // Saturating stall and tile counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_tile_cnt  <= '0;
        end else begin
            if ((r_fstate == F_FETCH) && (r_rows_left != 13'd0) && !w_credit_ok && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (r_tile_done && (r_tile_cnt != '1))
                r_tile_cnt <= r_tile_cnt + 16'd1;
        end
    end

    assign stall_cycles_o = r_stall_cnt;
    assign tiles_loaded_o = r_tile_cnt;
`else
    assign stall_cycles_o = '0;
    assign tiles_loaded_o = '0;
`endif

    assign cmd_ready_o         = (r_fstate == F_IDLE);
    assign fetch_done_o        = r_fetch_done;
    assign mem_rd_en_o         = r_mem_rd_en;
    assign mem_addr_o          = r_mem_addr;
    assign fifo_write_en_o     = (r_fstate != F_IDLE);
    assign fifo_sending_data_o = w_rd_counted;
    assign fifo_read_en_o      = (r_lstate == L_LOAD);
    assign array_shift_o       = r_shift;
    assign tile_done_o         = r_tile_done;
    assign weights_avail_o     = r_avail;
    assign occupancy_o         = r_occ;
endmodule

// File: tb/tb_weight_fifo_sched.sv
// tb/tb_weight_fifo_sched.sv - scoreboard bench for weight_fifo_sched
module tb_weight_fifo_sched;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_base = '0;
    logic [7:0]  cmd_num = '0;
    logic        cmd_ready, fetch_done, mem_rd_en, fifo_write_en, fifo_sending, fifo_read_en;
    logic [15:0] mem_addr;
    logic        mem_rd_valid = 1'b0;
    logic        load_req = 1'b0;
    logic        array_shift, tile_done, weights_avail;
    logic [7:0]  occupancy;
    logic [31:0] stall_cycles;
    logic [15:0] tiles_loaded;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    weight_fifo_sched dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_base_addr_i(cmd_base), .cmd_num_tiles_i(cmd_num),
        .cmd_ready_o(cmd_ready), .fetch_done_o(fetch_done),
        .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rd_valid_i(mem_rd_valid),
        .fifo_write_en_o(fifo_write_en), .fifo_sending_data_o(fifo_sending),
        .fifo_read_en_o(fifo_read_en), .load_req_i(load_req),
        .array_shift_o(array_shift), .tile_done_o(tile_done),
        .weights_avail_o(weights_avail), .occupancy_o(occupancy),
        .stall_cycles_o(stall_cycles), .tiles_loaded_o(tiles_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: a strobe registered at edge k is returned as valid sampled at edge k+3
    logic [15:0] hist = '0;
    logic        inject = 1'b0;
    logic        mem_inj = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) hist = '0;
        else     hist = {hist[14:0], mem_rd_en};
        mem_rd_valid = hist[LAT] | inject;
        mem_inj      = inject;
    end

    // Scoreboard queues filled by stimulus
    logic [15:0] q_addr[$];
    int          q_fdone[$];
    int          q_tdone[$];
    int          rd_cnt = 0, fdone_cnt = 0, tiles_seen = 0;

    // Occupancy/inflight model and monitor; all values describe the state after the latest edge
    int occ_m = 0, infl_m = 0, p_cv = 0, p_rd = 0, occ_prev = 0;
    bit p_rst = 1'b1;
    int viol = 0, simul = 0;
    always @(negedge clk) begin
        occ_prev = occ_m;
        if (p_rst) begin
            occ_m  = 0;
            infl_m = 0;
        end else begin
            occ_m  = occ_m + p_cv - p_rd;
            infl_m = infl_m + (mem_rd_en ? 1 : 0) - p_cv;
        end
        if (cyc > 0) begin
            chk("occupancy", 32'(occupancy), 32'(occ_m));
            chk("weights_avail", 32'(weights_avail), 32'(occ_m >= 32));
            if (!p_rst && p_cv == 1 && p_rd == 1) begin
                simul++;
                chk("occ_hold_simul", 32'(occupancy), 32'(occ_prev));
            end
            if (occ_m + infl_m > 128 || occ_m < 0 || infl_m < 0) viol++;
            if (!rst) begin
                if (mem_rd_en) begin
                    rd_cnt++;
                    if (q_addr.size() == 0) chk("addr_unexpected", 32'(mem_addr), 32'hffff_ffff);
                    else chk("mem_addr", 32'(mem_addr), 32'(q_addr.pop_front()));
                end
                if (fetch_done) begin
                    int e;
                    fdone_cnt++;
                    if (q_fdone.size() == 0) chk("fetch_done_unexpected", 32'(cyc), 32'hffff_ffff);
                    else begin
                        e = q_fdone.pop_front();
                        if (e >= 0) chk("fetch_done_cycle", 32'(cyc), 32'(e));
                    end
                end
                if (tile_done) begin
                    int e;
                    tiles_seen++;
                    chk("shift_with_done", 32'(array_shift), 32'd1);
                    if (q_tdone.size() == 0) chk("tile_done_unexpected", 32'(cyc), 32'hffff_ffff);
                    else begin
                        e = q_tdone.pop_front();
                        if (e >= 0) chk("tile_done_cycle", 32'(cyc), 32'(e));
                    end
                end
            end
        end
        p_rst = rst;
        p_cv  = (mem_rd_valid && !mem_inj) ? 1 : 0;
        p_rd  = fifo_read_en ? 1 : 0;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; accept edge n = cyc+1; rel < 0 means done timing not predicted
    task automatic send_cmd(input logic [15:0] base, input logic [7:0] num, input int rel);
        int n;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_base  = base;
        cmd_num   = num;
        cmd_valid = 1'b1;
        n = cyc + 1;
        for (int i = 0; i < int'(num) * 32; i++) q_addr.push_back(base + 16'(i));
        q_fdone.push_back(rel < 0 ? -1 : n + rel);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        chk("write_en_busy", 32'(fifo_write_en), 32'd1);
    endtask

    task automatic wait_fdone(input int start, input string name);
        int i = 0;
        while (fdone_cnt == start && i < 3000) begin @(negedge clk); i++; end
        chk(name, 32'(fdone_cnt != start), 32'd1);
    endtask

    task automatic wait_read_en(input string name);
        int i = 0;
        while (!fifo_read_en && i < 3000) begin @(negedge clk); i++; end
        chk(name, 32'(fifo_read_en), 32'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_fetch_done", 32'(fetch_done), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_write_en", 32'(fifo_write_en), 32'd0);
        chk("rst_read_en", 32'(fifo_read_en), 32'd0);
        chk("rst_shift", 32'(array_shift), 32'd0);
        chk("rst_tile_done", 32'(tile_done), 32'd0);
        chk("rst_avail", 32'(weights_avail), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_tiles", 32'(tiles_loaded), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        load_req  = 1'b0;
        cmd_valid = 1'b0;
        q_addr.delete();
        q_fdone.delete();
        q_tdone.delete();
        repeat (n) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, r0, t0, s0, n;

        // Reset and single-tile fetch
        @(negedge clk);
        do_reset(3);
        tick(1);
        f0 = fdone_cnt; r0 = rd_cnt;
        send_cmd(16'h0010, 8'd1, 34);
        wait_fdone(f0, "s1_fetch_done");
        tick(2);
        chk("s1_rows", 32'(rd_cnt - r0), 32'd32);
        chk("s1_occ", 32'(occupancy), 32'd32);
        chk("s1_avail", 32'(weights_avail), 32'd1);

        // Load that tile: read 32 cycles, done 32 edges after grant
        load_req = 1'b1;
        q_tdone.push_back(cyc + 1 + 32);
        wait_read_en("s1_grant");
        load_req = 1'b0;
        tick(40);
        chk("s1_occ_after_load", 32'(occupancy), 32'd0);

        // Load pending while occupancy climbs to 31
        load_req = 1'b1;
        f0 = fdone_cnt;
        n = cyc + 1;
        q_tdone.push_back(n + 67);
        send_cmd(16'h0100, 8'd1, 34);
        tick(33);
        chk("s3_occ31", 32'(occupancy), 32'd31);
        chk("s3_no_read", 32'(fifo_read_en), 32'd0);
        wait_read_en("s3_grant");
        chk("s3_grant_cycle", 32'(cyc), 32'(n + 35));
        load_req = 1'b0;
        wait_fdone(f0, "s3_fetch_done");
        tick(40);
        chk("s3_occ_end", 32'(occupancy), 32'd0);

        // Five tiles with no loads: credit caps issue at 128
        f0 = fdone_cnt; r0 = rd_cnt;
        send_cmd(16'h1000, 8'd5, -1);
        tick(200);
        chk("s2_issued_cap", 32'(rd_cnt - r0), 32'd128);
        chk("s2_occ_full", 32'(occupancy), 32'd128);
        chk("s2_not_done", 32'(fdone_cnt - f0), 32'd0);
`ifdef WFIFO_SCHED_PERF_EN
        chk("s2_stall_nonzero", 32'(stall_cycles > 0), 32'd1);
`else
        chk("s2_stall_tied", stall_cycles, 32'd0);
`endif
        load_req = 1'b1;
        q_tdone.push_back(-1);
        wait_read_en("s2_grant");
        load_req = 1'b0;
        wait_fdone(f0, "s2_fetch_done");
        tick(5);
        chk("s2_all_rows", 32'(rd_cnt - r0), 32'd160);
        chk("s2_occ_end", 32'(occupancy), 32'd128);

        // Concurrent fetch and load from a full FIFO
        f0 = fdone_cnt; t0 = tiles_seen; s0 = simul;
        for (int i = 0; i < 6; i++) q_tdone.push_back(-1);
        load_req = 1'b1;
        send_cmd(16'h2000, 8'd2, -1);
        wait_fdone(f0, "s4_fetch_done");
        begin
            int i = 0;
            while (tiles_seen < t0 + 6 && i < 3000) begin @(negedge clk); i++; end
        end
        load_req = 1'b0;
        tick(3);
        chk("s4_tiles", 32'(tiles_seen - t0), 32'd6);
        chk("s4_occ_end", 32'(occupancy), 32'd0);
        chk("s4_simul_seen", 32'(simul > s0), 32'd1);
`ifdef WFIFO_SCHED_PERF_EN
        chk("perf_tiles", 32'(tiles_loaded), 32'd9);
`else
        chk("perf_tiles_tied", 32'(tiles_loaded), 32'd0);
`endif

        // Stray return while idle is ignored
        inject = 1'b1;
        @(negedge clk);
        chk("idle_valid_driven", 32'(mem_rd_valid), 32'd1);
        chk("idle_not_forwarded", 32'(fifo_sending), 32'd0);
        inject = 1'b0;
        tick(2);
        chk("idle_occ", 32'(occupancy), 32'd0);

        // Zero-tile command
        f0 = fdone_cnt; r0 = rd_cnt;
        send_cmd(16'h3000, 8'd0, 1);
        tick(4);
        chk("zero_no_reads", 32'(rd_cnt - r0), 32'd0);
        chk("zero_done", 32'(fdone_cnt - f0), 32'd1);

        // Address wrap
        f0 = fdone_cnt;
        send_cmd(16'hFFF0, 8'd1, 34);
        wait_fdone(f0, "wrap_fetch_done");
        tick(2);
        chk("wrap_occ", 32'(occupancy), 32'd32);

        // Reset in the middle of a tile load and a fetch
        load_req = 1'b1;
        send_cmd(16'h4000, 8'd2, -1);
        wait_read_en("s6_grant");
        tick(5);
        chk("s6_mid_fetch", 32'(fifo_write_en), 32'd1);
        do_reset(1);
        tick(4);
        f0 = fdone_cnt; r0 = rd_cnt;
        send_cmd(16'h0010, 8'd1, 34);
        wait_fdone(f0, "s6_fetch_done");
        tick(2);
        chk("s6_rows", 32'(rd_cnt - r0), 32'd32);
        chk("s6_occ", 32'(occupancy), 32'd32);

        chk("q_addr_empty", 32'(q_addr.size()), 32'd0);
        chk("q_fdone_empty", 32'(q_fdone.size()), 32'd0);
        chk("q_tdone_empty", 32'(q_tdone.size()), 32'd0);
        chk("credit_invariant", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
